// File: rtl/multi_alarm_clock.sv
// multi_alarm_clock: time-of-day clock with a one-second prescaler,
// 12/24-hour display mapping, validated register writes and N_ALARMS
// independent alarms with auto-clearing ring and optional snooze.
// Optional feature macro: SNOOZE_EN enables the SNOOZED alarm state.
module multi_alarm_clock #(
    parameter int TICK_DIV   = 100000000,
    parameter int N_ALARMS   = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_SEC = 300
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_valid,
    input  logic [2:0]          set_target,
    input  logic [1:0]          set_sel,
    input  logic [5:0]          set_data,
    input  logic                mode12,
    input  logic [N_ALARMS-1:0] alarm_en,
    input  logic                alarm_ack,
    input  logic                snooze,
    output logic [4:0]          hours,
    output logic [5:0]          minutes,
    output logic [5:0]          seconds,
    output logic                pm,
    output logic                tick,
    output logic [N_ALARMS-1:0] ringing,
    output logic                set_err
);

    localparam int PW   = $clog2(TICK_DIV);
    localparam int CMAX = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] RING_LAST  = CW'(RING_SEC - 1);
`ifdef SNOOZE_EN
    localparam logic [CW-1:0] SNOOZE_LAST = CW'(SNOOZE_SEC - 1);
`endif

    // Time-of-day and prescaler state
    logic [PW-1:0] r_presc;
    logic          r_tick;
    logic          r_set_err;
    logic [4:0]    r_hour;
    logic [5:0]    r_min;
    logic [5:0]    r_sec;

    // Alarm set points
    logic [4:0]    r_al_h [N_ALARMS];
    logic [5:0]    r_al_m [N_ALARMS];
    logic [5:0]    r_al_s [N_ALARMS];

    logic          w_range_ok;
    logic          w_tgt_ok;
    logic          w_wr_ok;
    logic          w_wr_err;
    logic          w_time_wr;
    logic          w_sec_wr;
    logic [PW-1:0] w_presc_nxt;
    logic [4:0]    w_hour_inc;
    logic [5:0]    w_min_inc;
    logic [5:0]    w_sec_inc;
    logic [4:0]    w_hours;
    logic [N_ALARMS-1:0] w_match;

    // Write validation: field range and target existence
    always_comb begin
        w_range_ok = 1'b0;
        case (set_sel)
            2'd0:    w_range_ok = (set_data <= 6'd23);
            2'd1:    w_range_ok = (set_data <= 6'd59);
            2'd2:    w_range_ok = (set_data <= 6'd59);
            default: w_range_ok = 1'b0;
        endcase
    end

    assign w_tgt_ok  = ({1'b0, set_target} <= 4'(N_ALARMS));
    assign w_wr_ok   = set_valid & w_range_ok & w_tgt_ok;
    assign w_wr_err  = set_valid & ~(w_range_ok & w_tgt_ok);
    assign w_time_wr = w_wr_ok & (set_target == 3'd0);
    assign w_sec_wr  = w_time_wr & (set_sel == 2'd2);

    // Prescaler next value; an accepted seconds write realigns the second
    always_comb begin
        if (w_sec_wr) begin
            w_presc_nxt = '0;
        end else if (r_presc == PRESC_LAST) begin
            w_presc_nxt = '0;
        end else begin
            w_presc_nxt = r_presc + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Post-increment time with all carries resolved in one cycle
    always_comb begin
        w_hour_inc = r_hour;
        w_min_inc  = r_min;
        w_sec_inc  = r_sec;
        if (r_tick) begin
            if (r_sec == 6'd59) begin
                w_sec_inc = 6'd0;
                if (r_min == 6'd59) begin
                    w_min_inc  = 6'd0;
                    w_hour_inc = (r_hour == 5'd23) ? 5'd0 : (r_hour + 5'd1);
                end else begin
                    w_min_inc = r_min + 6'd1;
                end
            end else begin
                w_sec_inc = r_sec + 6'd1;
            end
        end else begin
            w_sec_inc = r_sec;
        end
    end

    // Prescaler, tick pulse, error pulse and time-of-day registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc   <= '0;
            r_tick    <= 1'b0;
            r_set_err <= 1'b0;
            r_hour    <= 5'd0;
            r_min     <= 6'd0;
            r_sec     <= 6'd0;
        end else begin
            r_presc   <= w_presc_nxt;
            r_tick    <= (w_presc_nxt == PRESC_LAST);
            r_set_err <= w_wr_err;
            if (w_time_wr) begin
                case (set_sel)
                    2'd0:    r_hour <= set_data[4:0];
                    2'd1:    r_min  <= set_data;
                    2'd2:    r_sec  <= set_data;
                    default: r_sec  <= r_sec;
                endcase
            end else if (r_tick) begin
                r_hour <= w_hour_inc;
                r_min  <= w_min_inc;
                r_sec  <= w_sec_inc;
            end
        end
    end

    // Alarm set-point registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_ALARMS; k++) begin
                r_al_h[k] <= 5'd0;
                r_al_m[k] <= 6'd0;
                r_al_s[k] <= 6'd0;
            end
        end else begin
            for (int k = 0; k < N_ALARMS; k++) begin
                if (w_wr_ok && (set_target == 3'(k + 1))) begin
                    case (set_sel)
                        2'd0:    r_al_h[k] <= set_data[4:0];
                        2'd1:    r_al_m[k] <= set_data;
                        2'd2:    r_al_s[k] <= set_data;
                        default: r_al_s[k] <= r_al_s[k];
                    endcase
                end
            end
        end
    end

`ifdef SNOOZE_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RING = 2'd1, ST_SNZ = 2'd2} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RING = 2'd1} state_t;
    logic w_snooze_unused;
    assign w_snooze_unused = snooze;
`endif

    genvar g;
    generate
        for (g = 0; g < N_ALARMS; g++) begin : g_alarm
            state_t        r_state;
            logic [CW-1:0] r_cnt;
            logic          r_ring;

            // Matches only come from a real tick, never from a time write
            assign w_match[g] = r_tick & ~w_time_wr & alarm_en[g] &
                                (w_hour_inc == r_al_h[g]) &
                                (w_min_inc  == r_al_m[g]) &
                                (w_sec_inc  == r_al_s[g]);
            assign ringing[g] = r_ring;

            // Per-alarm state machine; a fresh match outranks ack/disable
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                    r_ring  <= 1'b0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (w_match[g]) begin
                                r_state <= ST_RING;
                                r_cnt   <= '0;
                                r_ring  <= 1'b1;
                            end else begin
                                r_ring  <= 1'b0;
                            end
                        end
                        ST_RING: begin
                            if (w_match[g]) begin
                                r_cnt   <= '0;
                                r_ring  <= 1'b1;
                            end else if (alarm_ack || !alarm_en[g]) begin
                                r_state <= ST_IDLE;
                                r_ring  <= 1'b0;
`ifdef SNOOZE_EN
                            end else if (snooze) begin
                                r_state <= ST_SNZ;
                                r_cnt   <= '0;
                                r_ring  <= 1'b0;
`endif
                            end else if (r_tick) begin
                                if (r_cnt == RING_LAST) begin
                                    r_state <= ST_IDLE;
                                    r_ring  <= 1'b0;
                                end else begin
                                    r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                                end
                            end
                        end
`ifdef SNOOZE_EN
                        ST_SNZ: begin
                            if (w_match[g]) begin
                                r_state <= ST_RING;
                                r_cnt   <= '0;
                                r_ring  <= 1'b1;
                            end else if (alarm_ack || !alarm_en[g]) begin
                                r_state <= ST_IDLE;
                                r_ring  <= 1'b0;
                            end else if (r_tick) begin
                                if (r_cnt == SNOOZE_LAST) begin
                                    r_state <= ST_RING;
                                    r_cnt   <= '0;
                                    r_ring  <= 1'b1;
                                end else begin
                                    r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
                                end
                            end
                        end
`endif
                        default: begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_ring  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    endgenerate

    // Display hour mapping for 12-hour mode (0 shows as 12)
    always_comb begin
        if (!mode12) begin
            w_hours = r_hour;
        end else if (r_hour == 5'd0) begin
            w_hours = 5'd12;
        end else if (r_hour > 5'd12) begin
            w_hours = r_hour - 5'd12;
        end else begin
            w_hours = r_hour;
        end
    end

    assign hours   = w_hours;
    assign minutes = r_min;
    assign seconds = r_sec;
    assign pm      = (r_hour >= 5'd12);
    assign tick    = r_tick;
    assign set_err = r_set_err;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Directed self-checking bench for multi_alarm_clock
// (TICK_DIV=4, N_ALARMS=2, RING_SEC=3, SNOOZE_SEC=2).
module tb_multi_alarm_clock;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       set_valid = 1'b0;
    logic [2:0] set_target = 3'd0;
    logic [1:0] set_sel = 2'd0;
    logic [5:0] set_data = 6'd0;
    logic       mode12 = 1'b0;
    logic [1:0] alarm_en = 2'b00;
    logic       alarm_ack = 1'b0;
    logic       snooze = 1'b0;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       pm;
    logic       tick;
    logic [1:0] ringing;
    logic       set_err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [1:0] exp_snz;

    multi_alarm_clock #(
        .TICK_DIV(4), .N_ALARMS(2), .RING_SEC(3), .SNOOZE_SEC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .set_valid(set_valid), .set_target(set_target),
        .set_sel(set_sel), .set_data(set_data), .mode12(mode12), .alarm_en(alarm_en),
        .alarm_ack(alarm_ack), .snooze(snooze), .hours(hours), .minutes(minutes),
        .seconds(seconds), .pm(pm), .tick(tick), .ringing(ringing), .set_err(set_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Caller is at a negedge; the write is sampled on the next posedge
    task automatic wr(input logic [2:0] t, input logic [1:0] s, input logic [5:0] d);
        set_valid  = 1'b1;
        set_target = t;
        set_sel    = s;
        set_data   = d;
        @(negedge clk);
        set_valid  = 1'b0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
`ifdef SNOOZE_EN
        exp_snz = 2'b00;
`else
        exp_snz = 2'b10;
`endif
        // Reset values
        #7;
        check("rst_hours", 32'(hours), 32'd0);
        check("rst_min", 32'(minutes), 32'd0);
        check("rst_sec", 32'(seconds), 32'd0);
        check("rst_pm", 32'(pm), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_ring", 32'(ringing), 32'd0);
        check("rst_err", 32'(set_err), 32'd0);
        mode12 = 1'b1;
        #1;
        check("rst_hours12", 32'(hours), 32'd12);
        @(negedge clk);
        rst_n = 1'b1;

        // 23:59:59 rolls over to midnight, shown as 12 AM
        wr(3'd0, 2'd0, 6'd23);
        wr(3'd0, 2'd1, 6'd59);
        wr(3'd0, 2'd2, 6'd59);
        check("wr_ok_err", 32'(set_err), 32'd0);
        check("pre_sec", 32'(seconds), 32'd59);
        check("pre_hours12", 32'(hours), 32'd11);
        check("pre_pm", 32'(pm), 32'd1);
        cyc(3);
        check("tick_pulse", 32'(tick), 32'd1);
        check("tick_sec_hold", 32'(seconds), 32'd59);
        cyc(1);
        check("wrap_sec", 32'(seconds), 32'd0);
        check("wrap_min", 32'(minutes), 32'd0);
        check("wrap_hours12", 32'(hours), 32'd12);
        check("wrap_pm", 32'(pm), 32'd0);
        check("tick_low", 32'(tick), 32'd0);
        mode12 = 1'b0;
        #1;
        check("wrap_hours24", 32'(hours), 32'd0);

        // Rejected writes
        wr(3'd0, 2'd0, 6'd24);
        check("err_h24", 32'(set_err), 32'd1);
        check("err_h24_hours", 32'(hours), 32'd0);
        wr(3'd0, 2'd1, 6'd60);
        check("err_m60", 32'(set_err), 32'd1);
        check("err_m60_min", 32'(minutes), 32'd0);
        check("err_m60_sec", 32'(seconds), 32'd0);
        wr(3'd0, 2'd3, 6'd0);
        check("err_sel3", 32'(set_err), 32'd1);
        wr(3'd3, 2'd2, 6'd5);
        check("err_tgt3", 32'(set_err), 32'd1);
        check("err_tick_sec", 32'(seconds), 32'd1);
        cyc(1);
        check("err_clear", 32'(set_err), 32'd0);

        // Write coinciding with tick wins and discards the increment
        cyc(2);
        check("coll_tick", 32'(tick), 32'd1);
        wr(3'd0, 2'd1, 6'd7);
        check("coll_min", 32'(minutes), 32'd7);
        check("coll_sec", 32'(seconds), 32'd1);

        // Afternoon hour in both display modes
        wr(3'd0, 2'd0, 6'd13);
        mode12 = 1'b1;
        #1;
        check("h13_12", 32'(hours), 32'd1);
        check("h13_pm", 32'(pm), 32'd1);
        mode12 = 1'b0;
        #1;
        check("h13_24", 32'(hours), 32'd13);
        wr(3'd0, 2'd0, 6'd0);
        wr(3'd0, 2'd1, 6'd0);

        // Alarm0 at 00:00:05 rings on the edge seconds becomes 5
        wr(3'd1, 2'd2, 6'd5);
        alarm_en = 2'b01;
        wr(3'd0, 2'd2, 6'd4);
        check("a0_sec4", 32'(seconds), 32'd4);
        check("a0_idle", 32'(ringing), 32'd0);
        cyc(3);
        check("a0_pre", 32'(ringing), 32'd0);
        cyc(1);
        check("a0_sec5", 32'(seconds), 32'd5);
        check("a0_ring", 32'(ringing), 32'd1);
        cyc(8);
        check("a0_ring_s7", 32'(ringing), 32'd1);
        cyc(4);
        check("a0_auto_s8", 32'(seconds), 32'd8);
        check("a0_auto_clr", 32'(ringing), 32'd0);

        // Ack stops ringing; ack on a match cycle loses to the match
        wr(3'd0, 2'd2, 6'd4);
        cyc(4);
        check("ack_ring", 32'(ringing), 32'd1);
        alarm_ack = 1'b1;
        cyc(1);
        alarm_ack = 1'b0;
        check("ack_clr", 32'(ringing), 32'd0);
        wr(3'd0, 2'd2, 6'd4);
        cyc(3);
        alarm_ack = 1'b1;
        cyc(1);
        alarm_ack = 1'b0;
        check("ack_match_sec", 32'(seconds), 32'd5);
        check("ack_match_ring", 32'(ringing), 32'd1);
        alarm_en = 2'b00;
        cyc(1);
        check("en_drop_clr", 32'(ringing), 32'd0);

        // Snooze on alarm1
        alarm_en = 2'b10;
        wr(3'd2, 2'd2, 6'd10);
        wr(3'd0, 2'd2, 6'd9);
        cyc(4);
        check("a1_sec10", 32'(seconds), 32'd10);
        check("a1_ring", 32'(ringing), 32'd2);
        snooze = 1'b1;
        cyc(1);
        snooze = 1'b0;
        check("snz_now", 32'(ringing), 32'(exp_snz));
        cyc(3);
        check("snz_s11", 32'(ringing), 32'(exp_snz));
        cyc(4);
        check("snz_s12_sec", 32'(seconds), 32'd12);
        check("snz_s12", 32'(ringing), 32'd2);
        alarm_ack = 1'b1;
        cyc(1);
        alarm_ack = 1'b0;
        check("snz_ack", 32'(ringing), 32'd0);

        // Asynchronous reset mid-ring and mid-prescaler
        wr(3'd0, 2'd2, 6'd9);
        cyc(4);
        check("ar_ring", 32'(ringing), 32'd2);
        cyc(2);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_sec", 32'(seconds), 32'd0);
        check("ar_min", 32'(minutes), 32'd0);
        check("ar_hours", 32'(hours), 32'd0);
        check("ar_pm", 32'(pm), 32'd0);
        check("ar_tick", 32'(tick), 32'd0);
        check("ar_ring0", 32'(ringing), 32'd0);
        check("ar_err", 32'(set_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(3);
        check("ar_tick_again", 32'(tick), 32'd1);
        check("ar_no_ring", 32'(ringing), 32'd0);
        cyc(1);
        check("ar_sec1", 32'(seconds), 32'd1);
        check("ar_no_ring2", 32'(ringing), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
